// File: rtl/deser160_pkg.sv
// Shared types and widths for the deser160 phase-scan calibration block.
package deser160_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PHASE_W = 8;
    localparam int unsigned TMR_W   = 8;
    localparam int unsigned WORD_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_WAITPS,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_RETURN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/deser160_run_tracker.sv
// Longest run of good phase steps; the earliest run wins a tie and the last
// scanned step acts as the closing boundary of a run still open there.
module deser160_run_tracker
    import deser160_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               eval,
    input  logic               good,
    input  logic               last,
    input  logic [PHASE_W-1:0] idx,
    output logic               valid,
    output logic [PHASE_W-1:0] target_c
);

    logic               in_run;
    logic [PHASE_W-1:0] cur_start;
    logic [PHASE_W-1:0] best_start;
    logic [PHASE_W-1:0] best_len;
    logic [PHASE_W-1:0] run_start_c;
    logic [PHASE_W-1:0] close_len_c;
    logic               close_c;

    // A run ends either on the first bad step or at the last scanned step.
    always_comb begin
        run_start_c = in_run ? cur_start : idx;
        close_c     = (in_run && !good) || (good && last);
        close_len_c = idx - run_start_c;
        target_c    = best_start + (best_len >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_run     <= 1'b0;
            cur_start  <= '0;
            best_start <= '0;
            best_len   <= '0;
            valid      <= 1'b0;
        end else if (clear) begin
            in_run     <= 1'b0;
            cur_start  <= '0;
            best_start <= '0;
            best_len   <= '0;
            valid      <= 1'b0;
        end else if (eval) begin
            if (good && !in_run) begin
                cur_start <= idx;
            end
            in_run <= good && !last;
            if (close_c && (!valid || (close_len_c > best_len))) begin
                best_start <= run_start_c;
                best_len   <= close_len_c;
                valid      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/deser160_phase_ctrl.sv
// Phase-scan calibration for the 160 MHz deserialiser: steps the clock phase,
// measures word stability at each step and returns to the centre of the best run.
module deser160_phase_ctrl
    import deser160_pkg::*;
#(
    parameter int unsigned NSTEPS     = 32,
    parameter int unsigned MEAS_LEN   = 256,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned PS_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WORD_W-1:0]  data,
    input  logic               psdone,
    output logic               sync,
    output logic               psen,
    output logic               psincdec,
    output logic               busy,
    output logic               locked,
    output logic               fail,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [PHASE_W-1:0] LAST_IDX    = PHASE_W'(NSTEPS - 1);
    localparam logic [CNT_W-1:0]   MEAS_LAST   = CNT_W'(MEAS_LEN - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]   TMO         = TMR_W'(PS_TIMEOUT);

    state_t             state;
    logic               sync_prev;
    logic [WORD_W-1:0]  last_word;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   tmr;
    logic [PHASE_W-1:0] step_idx;
    logic               bad_seen;
    logic               step_good;
    logic               sample_c;
    logic               word_bad_c;
    logic               run_valid;
    logic [PHASE_W-1:0] target_c;

    assign sample_c   = sync_prev;
    assign word_bad_c = (data != last_word);

    // Free-running word strobe and sampled-word history, independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= 1'b0;
            sync_prev <= 1'b0;
            last_word <= '0;
        end else begin
            sync      <= ~sync;
            sync_prev <= sync;
            if (sample_c) begin
                last_word <= data;
            end
        end
    end

    deser160_run_tracker u_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    ((state == ST_IDLE) && start),
        .eval     (state == ST_EVAL),
        .good     (step_good),
        .last     (step_idx == LAST_IDX),
        .idx      (step_idx),
        .valid    (run_valid),
        .target_c (target_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            psen      <= 1'b0;
            psincdec  <= 1'b0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
            phase     <= '0;
            cnt       <= '0;
            tmr       <= '0;
            step_idx  <= '0;
            bad_seen  <= 1'b0;
            step_good <= 1'b0;
        end else begin
            psen <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        locked   <= 1'b0;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                        step_idx <= '0;
                        cnt      <= '0;
                        psincdec <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt      <= '0;
                        bad_seen <= 1'b0;
                        state    <= ST_MEASURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (sample_c) begin
                        if (cnt == MEAS_LAST) begin
                            step_good <= !(bad_seen || word_bad_c);
                            state     <= ST_EVAL;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            bad_seen <= bad_seen || word_bad_c;
                        end
                    end
                end
                ST_EVAL: begin
                    if (step_idx != LAST_IDX) begin
                        step_idx <= step_idx + 1'b1;
                        psincdec <= 1'b1;
                        state    <= ST_STEP;
                    end else begin
                        psincdec <= 1'b0;
                        state    <= ST_RETURN;
                    end
                end
                ST_STEP: begin
                    psen  <= 1'b1;
                    tmr   <= TMR_W'(1);
                    state <= ST_WAITPS;
                end
                // psdone wins over a timeout landing on the same cycle.
                ST_WAITPS: begin
                    if (psdone) begin
                        phase <= psincdec ? phase + 1'b1 : phase - 1'b1;
                        cnt   <= '0;
                        state <= psincdec ? ST_SETTLE : ST_RETURN;
                    end else if (tmr == TMO) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_RETURN: begin
                    if (phase == target_c) begin
                        locked <= run_valid;
                        fail   <= !run_valid;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_STEP;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
